// File: rtl/calc2_port_scheduler_if.sv
// calc2_port_scheduler_if: issue and response bus between the port scheduler
// and the shared calc2 ALU.
interface calc2_port_scheduler_if #(
    parameter int DATA_W = 32
);
    logic              alu_valid;
    logic              alu_ready;
    logic [3:0]        alu_cmd;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [1:0]        alu_tag;
    logic [1:0]        alu_port;
    logic              alu_resp_valid;
    logic [1:0]        alu_resp;
    logic [DATA_W-1:0] alu_resp_data;
    logic [1:0]        alu_resp_tag;
    logic [1:0]        alu_resp_port;

    modport master (
        output alu_valid, alu_cmd, alu_op1, alu_op2, alu_tag, alu_port,
        input  alu_ready,
        input  alu_resp_valid, alu_resp, alu_resp_data, alu_resp_tag,
        input  alu_resp_port
    );

    modport slave (
        input  alu_valid, alu_cmd, alu_op1, alu_op2, alu_tag, alu_port,
        output alu_ready,
        output alu_resp_valid, alu_resp, alu_resp_data, alu_resp_tag,
        output alu_resp_port
    );
endinterface

// File: rtl/calc2_port_scheduler.sv
// calc2_port_scheduler: captures four two-cycle request ports into FIFOs,
// round-robins them onto one shared ALU and routes responses back.
module calc2_port_scheduler #(
    parameter int DATA_W          = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                c_clk,
    input  logic                reset,
    input  logic [15:0]         req_cmd_in,
    input  logic [4*DATA_W-1:0] req_data_in,
    input  logic [7:0]          req_tag_in,
    output logic [7:0]          out_resp,
    output logic [4*DATA_W-1:0] out_data,
    output logic [7:0]          out_tag,
    output logic [3:0]          port_full,
    output logic                err_unexpected,
    calc2_port_scheduler_if.master alu
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [3:0]        cmd;
        logic [1:0]        tag;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } entry_t;

    typedef enum logic {IDLE, OP2} cap_e;

    cap_e              st_q [4];
    cap_e              st_d [4];
    logic [3:0]        cap_cmd_q [4];
    logic [1:0]        cap_tag_q [4];
    logic [DATA_W-1:0] cap_op1_q [4];
    entry_t            mem_q [4][FIFO_DEPTH];
    logic [AW-1:0]     wr_q [4];
    logic [AW-1:0]     rd_q [4];
    logic [CW-1:0]     cnt_q [4];
    logic              rej_v_q [4];
    logic [1:0]        rej_tag_q [4];
    logic [1:0]        resp_q [4];
    logic [DATA_W-1:0] data_q [4];
    logic [1:0]        tag_q [4];
    logic [OW-1:0]     outst_q;
    logic [1:0]        rr_q;
    logic              lock_q;
    logic [1:0]        lock_port_q;
    logic              err_q;

    logic       found;
    logic [1:0] pick;
    logic [1:0] sel;
    logic       issue_v;
    logic       hs;
    logic       rsp_ok;
    entry_t     head;
    logic [3:0] push;
    logic [3:0] pop;
    logic [3:0] rej_new;

    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        for (int i = 0; i < 4; i++) begin
            if (!found && cnt_q[2'(rr_q + 2'(i))] != '0) begin
                found = 1'b1;
                pick  = 2'(rr_q + 2'(i));
            end
        end
    end

    // A stalled offer keeps its port until the ALU takes it.
    assign sel     = lock_q ? lock_port_q : pick;
    assign issue_v = found && (outst_q < OW'(MAX_OUTSTANDING));
    assign hs      = issue_v && alu.alu_ready;
    assign head    = mem_q[sel][rd_q[sel]];
    assign rsp_ok  = alu.alu_resp_valid && (outst_q != '0);

    assign alu.alu_valid = issue_v;
    assign alu.alu_cmd   = issue_v ? head.cmd : '0;
    assign alu.alu_op1   = issue_v ? head.op1 : '0;
    assign alu.alu_op2   = issue_v ? head.op2 : '0;
    assign alu.alu_tag   = issue_v ? head.tag : '0;
    assign alu.alu_port  = issue_v ? sel : '0;

    assign err_unexpected = err_q;

    always_comb begin
        push      = '0;
        pop       = '0;
        rej_new   = '0;
        port_full = '0;
        out_resp  = '0;
        out_data  = '0;
        out_tag   = '0;
        for (int p = 0; p < 4; p++) begin
            st_d[p] = st_q[p];
            unique case (st_q[p])
                IDLE: if (req_cmd_in[4*p +: 4] != 4'd0) st_d[p] = OP2;
                OP2:  st_d[p] = IDLE;
            endcase
            pop[p]     = hs && (sel == 2'(p));
            push[p]    = (st_q[p] == OP2)
                         && ((cnt_q[p] != CW'(FIFO_DEPTH)) || pop[p]);
            rej_new[p] = (st_q[p] == OP2) && !push[p];
            port_full[p] = (cnt_q[p] == CW'(FIFO_DEPTH));
            out_resp[2*p +: 2]         = resp_q[p];
            out_data[DATA_W*p +: DATA_W] = data_q[p];
            out_tag[2*p +: 2]          = tag_q[p];
        end
    end

    always_ff @(posedge c_clk) begin
        for (int p = 0; p < 4; p++) begin
            if (push[p]) begin
                mem_q[p][wr_q[p]] <= '{cmd: cap_cmd_q[p],
                                       tag: cap_tag_q[p],
                                       op1: cap_op1_q[p],
                                       op2: req_data_in[DATA_W*p +: DATA_W]};
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int p = 0; p < 4; p++) begin
                st_q[p]      <= IDLE;
                cap_cmd_q[p] <= '0;
                cap_tag_q[p] <= '0;
                cap_op1_q[p] <= '0;
                wr_q[p]      <= '0;
                rd_q[p]      <= '0;
                cnt_q[p]     <= '0;
                rej_v_q[p]   <= 1'b0;
                rej_tag_q[p] <= '0;
                resp_q[p]    <= '0;
                data_q[p]    <= '0;
                tag_q[p]     <= '0;
            end
            outst_q     <= '0;
            rr_q        <= '0;
            lock_q      <= 1'b0;
            lock_port_q <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                st_q[p] <= st_d[p];
                if (st_q[p] == IDLE && req_cmd_in[4*p +: 4] != 4'd0) begin
                    cap_cmd_q[p] <= req_cmd_in[4*p +: 4];
                    cap_tag_q[p] <= req_tag_in[2*p +: 2];
                    cap_op1_q[p] <= req_data_in[DATA_W*p +: DATA_W];
                end
                if (push[p]) wr_q[p] <= wr_q[p] + 1'b1;
                if (pop[p])  rd_q[p] <= rd_q[p] + 1'b1;
                cnt_q[p] <= cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
                // ALU responses own the output; a reject waits one slot.
                if (rsp_ok && alu.alu_resp_port == 2'(p)) begin
                    resp_q[p] <= alu.alu_resp;
                    data_q[p] <= alu.alu_resp_data;
                    tag_q[p]  <= alu.alu_resp_tag;
                    if (rej_new[p] && !rej_v_q[p]) begin
                        rej_v_q[p]   <= 1'b1;
                        rej_tag_q[p] <= cap_tag_q[p];
                    end
                end else if (rej_v_q[p] || rej_new[p]) begin
                    resp_q[p]  <= 2'd3;
                    data_q[p]  <= '0;
                    tag_q[p]   <= rej_v_q[p] ? rej_tag_q[p] : cap_tag_q[p];
                    rej_v_q[p] <= 1'b0;
                end else begin
                    resp_q[p] <= '0;
                    data_q[p] <= '0;
                    tag_q[p]  <= '0;
                end
            end
            if (hs) rr_q <= sel + 2'd1;
            lock_q      <= issue_v && !alu.alu_ready;
            lock_port_q <= sel;
            outst_q     <= outst_q + OW'(hs) - OW'(rsp_ok);
            if (alu.alu_resp_valid && outst_q == '0) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_calc2_port_scheduler.sv
// tb_calc2_port_scheduler: directed scenarios plus randomized traffic checked
// every cycle against a queue-based model of the scheduler.
module tb_calc2_port_scheduler;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int MAXO  = 8;

    logic            c_clk = 1'b0;
    logic            reset;
    logic [15:0]     req_cmd_in;
    logic [4*DW-1:0] req_data_in;
    logic [7:0]      req_tag_in;
    logic [7:0]      out_resp;
    logic [4*DW-1:0] out_data;
    logic [7:0]      out_tag;
    logic [3:0]      port_full;
    logic            err_unexpected;

    calc2_port_scheduler_if #(.DATA_W(DW)) alu_if ();

    calc2_port_scheduler #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .c_clk          (c_clk),
        .reset          (reset),
        .req_cmd_in     (req_cmd_in),
        .req_data_in    (req_data_in),
        .req_tag_in     (req_tag_in),
        .out_resp       (out_resp),
        .out_data       (out_data),
        .out_tag        (out_tag),
        .port_full      (port_full),
        .err_unexpected (err_unexpected),
        .alu            (alu_if)
    );

    always #5 c_clk = ~c_clk;

    logic [3:0]  cmd_a [4];
    logic [1:0]  tag_a [4];
    logic [31:0] dat_a [4];

    always_comb begin
        req_cmd_in  = '0;
        req_tag_in  = '0;
        req_data_in = '0;
        for (int p = 0; p < 4; p++) begin
            req_cmd_in[4*p +: 4]   = cmd_a[p];
            req_tag_in[2*p +: 2]   = tag_a[p];
            req_data_in[DW*p +: DW] = dat_a[p];
        end
    end

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  port;
    } ent_t;

    // Reference model state
    ent_t        fq [4][$];
    ent_t        alu_q [$];
    bit          cap_v [4];
    ent_t        cap_e [4];
    bit          held [4];
    logic [1:0]  held_tag [4];
    logic [1:0]  e_resp [4];
    logic [31:0] e_data [4];
    logic [1:0]  e_tag [4];
    bit          e_err;
    int          outst;
    int          rr;
    bit          lk;
    int          lkp;

    int checks = 0;
    int errors = 0;

    task automatic ck(input string nm, input logic [127:0] got,
                      input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < 4; p++) begin
            fq[p].delete();
            cap_v[p]    = 1'b0;
            cap_e[p]    = '0;
            held[p]     = 1'b0;
            held_tag[p] = '0;
            e_resp[p]   = '0;
            e_data[p]   = '0;
            e_tag[p]    = '0;
        end
        alu_q.delete();
        e_err = 1'b0;
        outst = 0;
        rr    = 0;
        lk    = 1'b0;
        lkp   = 0;
    endfunction

    function automatic void m_pick(output bit v, output int s);
        v = 1'b0;
        s = 0;
        if (outst < MAXO) begin
            if (lk) begin
                v = 1'b1;
                s = lkp;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    int j;
                    j = (rr + i) % 4;
                    if (!v && fq[j].size() > 0) begin
                        v = 1'b1;
                        s = j;
                    end
                end
            end
        end
    endfunction

    function automatic void m_update(input bit v, input int s);
        bit   hs;
        bit   routed;
        bit   newrej;
        int   ob;
        ent_t h;
        logic [1:0] rtag;
        if (reset) begin
            model_reset();
            return;
        end
        ob = outst;
        hs = v && alu_if.alu_ready;
        if (hs) begin
            h = fq[s].pop_front();
            alu_q.push_back(h);
            rr = (s + 1) % 4;
        end
        lk  = v && !alu_if.alu_ready;
        lkp = s;
        routed = alu_if.alu_resp_valid && ob > 0;
        if (alu_if.alu_resp_valid && ob == 0) e_err = 1'b1;
        outst = ob + int'(hs) - int'(routed);
        for (int p = 0; p < 4; p++) begin
            newrej = 1'b0;
            rtag   = cap_e[p].tag;
            if (cap_v[p]) begin
                if (fq[p].size() < DEPTH) begin
                    h      = cap_e[p];
                    h.op2  = dat_a[p];
                    h.port = 2'(p);
                    fq[p].push_back(h);
                end else begin
                    newrej = 1'b1;
                end
                cap_v[p] = 1'b0;
            end else if (cmd_a[p] != 4'd0) begin
                cap_v[p]     = 1'b1;
                cap_e[p]     = '0;
                cap_e[p].cmd = cmd_a[p];
                cap_e[p].tag = tag_a[p];
                cap_e[p].op1 = dat_a[p];
            end
            if (routed && alu_if.alu_resp_port == 2'(p)) begin
                e_resp[p] = alu_if.alu_resp;
                e_data[p] = alu_if.alu_resp_data;
                e_tag[p]  = alu_if.alu_resp_tag;
                if (newrej && !held[p]) begin
                    held[p]     = 1'b1;
                    held_tag[p] = rtag;
                end
            end else if (held[p]) begin
                e_resp[p] = 2'd3;
                e_data[p] = '0;
                e_tag[p]  = held_tag[p];
                held[p]   = 1'b0;
            end else if (newrej) begin
                e_resp[p] = 2'd3;
                e_data[p] = '0;
                e_tag[p]  = rtag;
            end else begin
                e_resp[p] = '0;
                e_data[p] = '0;
                e_tag[p]  = '0;
            end
        end
    endfunction

    task automatic step();
        bit              v;
        int              s;
        ent_t            h;
        logic [71:0]     eb;
        logic [7:0]      er;
        logic [7:0]      et;
        logic [127:0]    ed;
        logic [3:0]      ef;
        @(negedge c_clk);
        m_pick(v, s);
        eb = '0;
        if (v) begin
            h  = fq[s][0];
            eb = {h.cmd, h.op1, h.op2, h.tag, 2'(s)};
        end
        for (int p = 0; p < 4; p++) begin
            er[2*p +: 2]   = e_resp[p];
            et[2*p +: 2]   = e_tag[p];
            ed[DW*p +: DW] = e_data[p];
            ef[p]          = (fq[p].size() == DEPTH);
        end
        ck("alu_valid", 128'(alu_if.alu_valid), 128'(v));
        ck("alu_bus", 128'({alu_if.alu_cmd, alu_if.alu_op1, alu_if.alu_op2,
                            alu_if.alu_tag, alu_if.alu_port}), 128'(eb));
        ck("out_resp", 128'(out_resp), 128'(er));
        ck("out_data", out_data, ed);
        ck("out_tag", 128'(out_tag), 128'(et));
        ck("port_full", 128'(port_full), 128'(ef));
        ck("err_unexpected", 128'(err_unexpected), 128'(e_err));
        m_update(v, s);
        @(posedge c_clk);
        #1;
    endtask

    task automatic clr();
        for (int p = 0; p < 4; p++) begin
            cmd_a[p] = '0;
            tag_a[p] = '0;
            dat_a[p] = '0;
        end
        alu_if.alu_resp_valid = 1'b0;
        alu_if.alu_resp       = '0;
        alu_if.alu_resp_data  = '0;
        alu_if.alu_resp_tag   = '0;
        alu_if.alu_resp_port  = '0;
    endtask

    task automatic do_rst();
        reset = 1'b1;
        clr();
        alu_if.alu_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic respond(input logic [1:0] port, input logic [1:0] tag,
                           input logic [1:0] code, input logic [31:0] d);
        alu_if.alu_resp_valid = 1'b1;
        alu_if.alu_resp_port  = port;
        alu_if.alu_resp_tag   = tag;
        alu_if.alu_resp       = code;
        alu_if.alu_resp_data  = d;
    endtask

    initial begin
        int   n;
        ent_t h;
        reset = 1'b1;
        clr();
        alu_if.alu_ready = 1'b0;
        repeat (2) @(posedge c_clk);
        #1;
        model_reset();
        step();
        reset = 1'b0;

        // Single request, issue and response routing
        do_rst();
        alu_if.alu_ready = 1'b1;
        cmd_a[0] = 4'd1; tag_a[0] = 2'd2; dat_a[0] = 32'd5;
        step();
        cmd_a[0] = 4'd0; dat_a[0] = 32'd7;
        step();
        ck("t1_valid", 128'(alu_if.alu_valid), 128'(1));
        ck("t1_bus", 128'({alu_if.alu_cmd, alu_if.alu_op1, alu_if.alu_op2,
                           alu_if.alu_tag, alu_if.alu_port}),
           128'({4'd1, 32'd5, 32'd7, 2'd2, 2'd0}));
        step();
        void'(alu_q.pop_front());
        respond(2'd0, 2'd2, 2'd1, 32'd12);
        step();
        clr();
        ck("t1_resp", 128'(out_resp[1:0]), 128'(1));
        ck("t1_data", 128'(out_data[31:0]), 128'(12));
        ck("t1_tag", 128'(out_tag[1:0]), 128'(2));
        step();

        // Round-robin order across all four ports, then pointer wrap
        do_rst();
        alu_if.alu_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            cmd_a[p] = 4'(p + 1); tag_a[p] = 2'(p); dat_a[p] = 32'(10 * p);
        end
        step();
        clr();
        step();
        for (int i = 0; i < 4; i++) begin
            ck("t2_rr", 128'({alu_if.alu_valid, alu_if.alu_port}),
               128'({1'b1, 2'(i)}));
            step();
        end
        cmd_a[0] = 4'd3; cmd_a[2] = 4'd4;
        step();
        clr();
        step();
        ck("t2_wrap0", 128'({alu_if.alu_valid, alu_if.alu_port}),
           128'({1'b1, 2'd0}));
        step();
        ck("t2_wrap2", 128'({alu_if.alu_valid, alu_if.alu_port}),
           128'({1'b1, 2'd2}));
        step();

        // FIFO full and reject on port 1
        do_rst();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) ck("t3_full", 128'(port_full[1]), 128'(1));
            cmd_a[1] = 4'd2;
            tag_a[1] = (k == 4) ? 2'd3 : 2'(k);
            dat_a[1] = 32'(100 + k);
            step();
            cmd_a[1] = 4'd0;
            step();
        end
        ck("t3_rej_resp", 128'(out_resp[3:2]), 128'(3));
        ck("t3_rej_tag", 128'(out_tag[3:2]), 128'(3));
        ck("t3_rej_data", 128'(out_data[63:32]), 128'(0));
        alu_if.alu_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (alu_if.alu_valid) n++;
            step();
        end
        ck("t3_issues", 128'(n), 128'(4));

        // Outstanding limit
        do_rst();
        alu_if.alu_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            clr();
            if (c < 6 && c % 2 == 0) begin
                for (int p = 0; p < 3; p++) begin
                    cmd_a[p] = 4'd5; tag_a[p] = 2'(c / 2);
                    dat_a[p] = 32'(c + p);
                end
            end
            if (alu_if.alu_valid) n++;
            step();
        end
        ck("t4_issues", 128'(n), 128'(8));
        ck("t4_stall", 128'(alu_if.alu_valid), 128'(0));
        h = alu_q.pop_front();
        respond(h.port, h.tag, 2'd1, h.op1 + h.op2);
        step();
        clr();
        ck("t4_ninth", 128'(alu_if.alu_valid), 128'(1));
        ck("t4_resp", 128'(out_resp[2*h.port +: 2]), 128'(1));
        step();

        // Reject colliding with an ALU response on port 2
        do_rst();
        alu_if.alu_ready = 1'b1;
        cmd_a[2] = 4'd1; tag_a[2] = 2'd0; dat_a[2] = 32'd1;
        step();
        cmd_a[2] = 4'd0;
        step();
        step();
        alu_if.alu_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cmd_a[2] = 4'd6; tag_a[2] = 2'd2; dat_a[2] = 32'(k);
            step();
            cmd_a[2] = 4'd0;
            step();
        end
        cmd_a[2] = 4'd7; tag_a[2] = 2'd1;
        step();
        cmd_a[2] = 4'd0;
        void'(alu_q.pop_front());
        respond(2'd2, 2'd0, 2'd1, 32'd99);
        step();
        clr();
        ck("t5_alu_resp", 128'(out_resp[5:4]), 128'(1));
        ck("t5_alu_data", 128'(out_data[95:64]), 128'(99));
        step();
        ck("t5_rej_resp", 128'(out_resp[5:4]), 128'(3));
        ck("t5_rej_tag", 128'(out_tag[5:4]), 128'(1));
        step();

        // Reset mid-capture, then a stray response
        do_rst();
        alu_if.alu_ready = 1'b1;
        cmd_a[0] = 4'd1; tag_a[0] = 2'd1; dat_a[0] = 32'd3;
        step();
        reset = 1'b1;
        cmd_a[0] = 4'd0; dat_a[0] = 32'd4;
        step();
        reset = 1'b0;
        ck("t6_valid", 128'(alu_if.alu_valid), 128'(0));
        ck("t6_outs", {out_resp, out_tag, port_full, err_unexpected},
           128'(0));
        ck("t6_data", out_data, 128'(0));
        step();
        step();
        ck("t6_noissue", 128'(alu_if.alu_valid), 128'(0));
        respond(2'd0, 2'd1, 2'd1, 32'd5);
        step();
        clr();
        ck("t6_err", 128'(err_unexpected), 128'(1));
        ck("t6_resp", 128'(out_resp), 128'(0));
        step();

        // Randomized traffic
        do_rst();
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 4; p++) begin
                dat_a[p] = $urandom;
                tag_a[p] = 2'($urandom);
                if (cap_v[p]) cmd_a[p] = 4'($urandom);
                else if ($urandom_range(0, 2) == 0)
                    cmd_a[p] = 4'($urandom_range(1, 15));
                else cmd_a[p] = 4'd0;
            end
            alu_if.alu_ready = ($urandom_range(0, 9) < 7);
            alu_if.alu_resp_valid = 1'b0;
            if (alu_q.size() > 0 && $urandom_range(0, 1) == 0) begin
                h = alu_q.pop_front();
                respond(h.port, h.tag, 2'($urandom_range(1, 3)),
                        h.op1 + h.op2);
            end
            if (c % 500 == 499) reset = 1'b1;
            step();
            reset = 1'b0;
        end
        clr();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
